// File: rtl/shift_link_ctrl_if.sv
// Handshake and strobe bundle between a word producer and the shift-link sequencer.
interface shift_link_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             abort;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic [WIDTH-1:0] piso_data;
    logic             piso_shift_load;
    logic             sipo_reset;
    logic             sipo_latch;
    logic             busy;
    logic             word_done;
    logic [15:0]      word_count;

    modport master (
        output abort, in_valid, in_data,
        input  in_ready, piso_data, piso_shift_load, sipo_reset, sipo_latch,
               busy, word_done, word_count
    );

    modport slave (
        input  abort, in_valid, in_data,
        output in_ready, piso_data, piso_shift_load, sipo_reset, sipo_latch,
               busy, word_done, word_count
    );
endinterface

// File: rtl/shift_link_ctrl.sv
// Sequences one PISO/SIPO pair as a single-word serial link: accept, load, shift WIDTH
// clocks, latch, optional idle gap.
module shift_link_ctrl #(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    shift_link_ctrl_if.slave  link
);
    localparam int          CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] SHIFT_LAST = CW'(WIDTH - 1);
    localparam logic [7:0]  GAP_LAST = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_LATCH = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CW-1:0]    shift_cnt_q, shift_cnt_d;
    logic [7:0]       gap_cnt_q, gap_cnt_d;
    logic [WIDTH-1:0] piso_data_q;
    logic             in_ready_q;
    logic             busy_q;
    logic             load_q;
    logic             sipo_reset_q;
    logic             latch_q;
    logic             done_q;
    logic [15:0]      word_count_q;
    logic             accept;

    // Abort in IDLE wins over a pending word: nothing is taken.
    assign accept = (state_q == ST_IDLE) && link.in_valid && !link.abort;

    always_comb begin
        state_d     = state_q;
        shift_cnt_d = shift_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                state_d     = ST_SHIFT;
                shift_cnt_d = '0;
            end
            ST_SHIFT: begin
                if (shift_cnt_q == SHIFT_LAST) state_d = ST_LATCH;
                else shift_cnt_d = shift_cnt_q + CW'(1);
            end
            ST_LATCH: begin
                state_d   = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                gap_cnt_d = '0;
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) state_d = ST_IDLE;
                else gap_cnt_d = gap_cnt_q + 8'd1;
            end
            default: state_d = ST_IDLE;
        endcase
        if (link.abort && (state_q != ST_IDLE)) state_d = ST_IDLE;
    end

    // Outputs are registered images of the next state, so each strobe lines up with its state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            shift_cnt_q  <= '0;
            gap_cnt_q    <= '0;
            piso_data_q  <= '0;
            in_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
            load_q       <= 1'b0;
            sipo_reset_q <= 1'b0;
            latch_q      <= 1'b0;
            done_q       <= 1'b0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            shift_cnt_q  <= shift_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            if (accept) piso_data_q <= link.in_data;
            in_ready_q   <= (state_d == ST_IDLE);
            busy_q       <= (state_d != ST_IDLE);
            load_q       <= (state_d == ST_LOAD);
            sipo_reset_q <= (state_d == ST_LOAD);
            latch_q      <= (state_d == ST_LATCH);
            done_q       <= (state_d == ST_LATCH);
            if (state_d == ST_LATCH) word_count_q <= word_count_q + 16'd1;
        end
    end

    assign link.in_ready        = in_ready_q;
    assign link.busy            = busy_q;
    assign link.piso_data       = piso_data_q;
    assign link.piso_shift_load = load_q;
    assign link.sipo_reset      = sipo_reset_q;
    assign link.sipo_latch      = latch_q;
    assign link.word_done       = done_q;
    assign link.word_count      = word_count_q;
endmodule

// File: tb/tb_shift_link_ctrl.sv
// Bench for shift_link_ctrl: two instances (no gap, 3-cycle gap) against a timestamp model
// plus behavioural PISO/SIPO shift registers to confirm the recovered word.
module tb_shift_link_ctrl;
    localparam int W  = 8;
    localparam int G0 = 0;
    localparam int G1 = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    shift_link_ctrl_if #(.WIDTH(W)) if0 ();
    shift_link_ctrl_if #(.WIDTH(W)) if1 ();

    shift_link_ctrl #(.WIDTH(W), .GAP_CYCLES(G0)) u_dut0 (.clk(clk), .reset_n(reset_n), .link(if0));
    shift_link_ctrl #(.WIDTH(W), .GAP_CYCLES(G1)) u_dut1 (.clk(clk), .reset_n(reset_n), .link(if1));

    logic         v_in  [2] = '{1'b0, 1'b0};
    logic [W-1:0] d_in  [2] = '{'0, '0};
    logic         ab_in [2] = '{1'b0, 1'b0};
    assign if0.in_valid = v_in[0];
    assign if0.in_data  = d_in[0];
    assign if0.abort    = ab_in[0];
    assign if1.in_valid = v_in[1];
    assign if1.in_data  = d_in[1];
    assign if1.abort    = ab_in[1];

    // Behavioural shift-register primitives wired to the controller strobes.
    logic [W-1:0] piso_sr [2] = '{'0, '0};
    logic [W-1:0] sipo_sr [2] = '{'0, '0};
    logic [W-1:0] par     [2] = '{'0, '0};
    always @(posedge clk) begin
        piso_sr[0] <= if0.piso_shift_load ? if0.piso_data : (piso_sr[0] << 1);
        piso_sr[1] <= if1.piso_shift_load ? if1.piso_data : (piso_sr[1] << 1);
        sipo_sr[0] <= if0.sipo_reset ? '0 : {sipo_sr[0][W-2:0], piso_sr[0][W-1]};
        sipo_sr[1] <= if1.sipo_reset ? '0 : {sipo_sr[1][W-2:0], piso_sr[1][W-1]};
    end

    // Reference model: each word is a timestamp; its phase is arithmetic on the cycle offset.
    int           ecount = 0;
    int           acc   [2] = '{-1, -1};
    logic [15:0]  cnt_m [2] = '{16'd0, 16'd0};
    logic [W-1:0] data_m[2] = '{'0, '0};
    int           lat_n [2] = '{0, 0};
    int           lat_cyc1[$];
    int checks = 0;
    int failures = 0;

    function automatic int gap_of(int d);
        return (d == 0) ? G0 : G1;
    endfunction

    function automatic bit active_at(int d, int cyc);
        int off;
        if (acc[d] < 0) return 1'b0;
        off = cyc - acc[d];
        return (off >= 1) && (off <= W + 2 + gap_of(d));
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(int d);
        int e;
        bit act;
        e = ecount;
        if (!reset_n) return;
        act = active_at(d, e);
        if (ab_in[d]) begin
            if (act) acc[d] = -1;
        end else if (!act && v_in[d]) begin
            acc[d]    = e;
            data_m[d] = d_in[d];
        end
        if (acc[d] >= 0 && (e + 1 - acc[d]) == W + 2) cnt_m[d] = cnt_m[d] + 16'd1;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            acc[d] = -1; cnt_m[d] = 16'd0; data_m[d] = '0;
        end
    endtask

    task automatic check_dut(int d);
        logic rdy, bsy, ld, sr, lt, dn;
        logic [W-1:0] pd;
        logic [15:0] wc;
        bit act, exp_lat;
        int off;
        if (d == 0) begin
            rdy = if0.in_ready; bsy = if0.busy; ld = if0.piso_shift_load; sr = if0.sipo_reset;
            lt = if0.sipo_latch; dn = if0.word_done; pd = if0.piso_data; wc = if0.word_count;
        end else begin
            rdy = if1.in_ready; bsy = if1.busy; ld = if1.piso_shift_load; sr = if1.sipo_reset;
            lt = if1.sipo_latch; dn = if1.word_done; pd = if1.piso_data; wc = if1.word_count;
        end
        act     = active_at(d, ecount);
        off     = ecount - acc[d];
        exp_lat = act && (off == W + 2);
        chk($sformatf("d%0d_in_ready_c%0d", d, ecount), 32'(rdy), 32'(!act));
        chk($sformatf("d%0d_busy_c%0d", d, ecount), 32'(bsy), 32'(act));
        chk($sformatf("d%0d_load_c%0d", d, ecount), 32'(ld), 32'(act && off == 1));
        chk($sformatf("d%0d_sipo_reset_c%0d", d, ecount), 32'(sr), 32'(act && off == 1));
        chk($sformatf("d%0d_latch_c%0d", d, ecount), 32'(lt), 32'(exp_lat));
        chk($sformatf("d%0d_done_c%0d", d, ecount), 32'(dn), 32'(exp_lat));
        chk($sformatf("d%0d_piso_data_c%0d", d, ecount), 32'(pd), 32'(data_m[d]));
        chk($sformatf("d%0d_word_count_c%0d", d, ecount), 32'(wc), 32'(cnt_m[d]));
        if (exp_lat)
            chk($sformatf("d%0d_sipo_word_c%0d", d, ecount), 32'(sipo_sr[d]), 32'(data_m[d]));
        if (lt) begin
            lat_n[d]++;
            par[d] = sipo_sr[d];
            if (d == 1) lat_cyc1.push_back(ecount);
        end
    endtask

    task automatic tick();
        model_edge(0);
        model_edge(1);
        @(posedge clk);
        ecount++;
        @(negedge clk);
        check_dut(0);
        check_dut(1);
        $display("cyc=%0d d0 rdy=%b ld=%b lat=%b wc=%0d | d1 rdy=%b lat=%b wc=%0d", ecount,
                 if0.in_ready, if0.piso_shift_load, if0.sipo_latch, if0.word_count,
                 if1.in_ready, if1.sipo_latch, if1.word_count);
    endtask

    task automatic send(int d, logic [W-1:0] data, int extra);
        v_in[d] = 1'b1; d_in[d] = data;
        tick();
        v_in[d] = 1'b0;
        repeat (extra) tick();
    endtask

    initial begin
        // Reset
        repeat (3) tick();
        chk("rst_in_ready", 32'(if0.in_ready), 32'd1);
        chk("rst_busy", 32'(if0.busy), 32'd0);
        chk("rst_word_count", 32'(if0.word_count), 32'd0);
        chk("rst_piso_data", 32'(if0.piso_data), 32'd0);
        reset_n = 1'b1;
        tick();

        // Single word, no gap
        send(0, 8'hD8, 10);
        chk("w1_sipo_out", 32'(par[0]), 32'hD8);
        chk("w1_word_count", 32'(if0.word_count), 32'd1);
        chk("w1_ready_after", 32'(if0.in_ready), 32'd1);

        // Back-to-back with in_valid held high
        v_in[0] = 1'b1; d_in[0] = 8'hD8;
        tick();
        d_in[0] = 8'h28;
        repeat (11) tick();
        v_in[0] = 1'b0;
        repeat (11) tick();
        chk("b2b_sipo_out", 32'(par[0]), 32'h28);
        chk("b2b_word_count", 32'(if0.word_count), 32'd3);
        chk("b2b_latch_total", 32'(lat_n[0]), 32'd3);

        // Gap instance: two words, latches 14 cycles apart
        lat_cyc1.delete();
        v_in[1] = 1'b1; d_in[1] = 8'hA5;
        tick();
        d_in[1] = 8'h3C;
        repeat (14) tick();
        v_in[1] = 1'b0;
        repeat (14) tick();
        chk("gap_latch_pulses", 32'(lat_cyc1.size()), 32'd2);
        if (lat_cyc1.size() == 2)
            chk("gap_latch_spacing", 32'(lat_cyc1[1] - lat_cyc1[0]), 32'd14);
        chk("gap_sipo_out", 32'(par[1]), 32'h3C);

        // Abort inside the gap
        send(1, 8'h77, 10);
        ab_in[1] = 1'b1;
        tick();
        ab_in[1] = 1'b0;
        chk("gap_abort_ready", 32'(if1.in_ready), 32'd1);

        // Abort in IDLE blocks the accept
        v_in[0] = 1'b1; ab_in[0] = 1'b1; d_in[0] = 8'h11;
        tick();
        v_in[0] = 1'b0; ab_in[0] = 1'b0;
        chk("idle_abort_ready", 32'(if0.in_ready), 32'd1);

        // Abort during SHIFT
        send(0, 8'h99, 4);
        ab_in[0] = 1'b1;
        tick();
        ab_in[0] = 1'b0;
        chk("abort_ready", 32'(if0.in_ready), 32'd1);
        repeat (10) tick();
        chk("abort_no_latch", 32'(lat_n[0]), 32'd3);
        chk("abort_word_count", 32'(if0.word_count), 32'd3);
        send(0, 8'h5A, 11);
        chk("after_abort_sipo", 32'(par[0]), 32'h5A);
        chk("after_abort_count", 32'(if0.word_count), 32'd4);

        // Asynchronous reset mid-word
        send(0, 8'hC3, 5);
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("arst_in_ready", 32'(if0.in_ready), 32'd1);
        chk("arst_busy", 32'(if0.busy), 32'd0);
        chk("arst_piso_data", 32'(if0.piso_data), 32'd0);
        chk("arst_strobes", 32'({if0.piso_shift_load, if0.sipo_reset, if0.sipo_latch, if0.word_done}), 32'd0);
        chk("arst_word_count", 32'(if0.word_count), 32'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (12) tick();
        chk("arst_no_latch", 32'(lat_n[0]), 32'd4);

        // word_count wrap
        force u_dut0.word_count_q = 16'hFFFF;
        #1;
        release u_dut0.word_count_q;
        cnt_m[0] = 16'hFFFF;
        chk("wrap_preload", 32'(if0.word_count), 32'hFFFF);
        send(0, 8'h81, 11);
        chk("wrap_count", 32'(if0.word_count), 32'd0);
        chk("wrap_latch_total", 32'(lat_n[0]), 32'd5);

        // Randomised traffic with occasional aborts on both instances
        for (int i = 0; i < 600; i++) begin
            for (int d = 0; d < 2; d++) begin
                v_in[d]  = ($urandom_range(0, 3) != 0);
                d_in[d]  = W'($urandom);
                ab_in[d] = ($urandom_range(0, 19) == 0);
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
